// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache, the dcache and the single-ported RAM.
// The slave modport is the arbiter's view. The master modport is the
// view of whatever drives the caches and models the RAM.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-ported RAM.
// The dcache wins ties. The icache is forced through once the dcache has
// completed STARVE_MAX back-to-back accesses while the icache was waiting.
// Every access passes through one IDLE arbitration cycle. Multi-word dcache
// transfers are therefore interleaved with arbitration.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic        CLK,
    input logic        RST,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t        state;
    logic [SW-1:0] scnt;
    logic          dReq;
    logic          starved;

    assign dReq    = bus.dREN | bus.dWEN;
    assign starved = bus.iREN && (scnt == SW'(STARVE_MAX));

    // Grant state machine and starvation counter.
    // A grant ends on ram_ready, or early when its owner withdraws.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dReq && !starved)
                        state <= DGRANT;
                    else if (bus.iREN)
                        state <= IGRANT;
                end
                IGRANT:  if (bus.ram_ready || !bus.iREN) state <= IDLE;
                DGRANT:  if (bus.ram_ready || !dReq)     state <= IDLE;
                default: state <= IDLE;
            endcase

            // starved implies scnt is saturated, so the increment can never wrap
            if (!bus.iREN)
                scnt <= '0;
            else if (state == IGRANT && bus.ram_ready)
                scnt <= '0;
            else if (state == DGRANT && bus.ram_ready && dReq && !starved)
                scnt <= scnt + SW'(1);
        end
    end

    // RAM strobes and stalls are decoded from the current grant.
    // Because they are not registered, a reset drops the strobes at once.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = bus.iREN;
        bus.dwait    = dReq;
        case (state)
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~bus.ram_ready;
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~bus.ram_ready;
            end
            default: ;
        endcase
    end

    // Both masters see the read data. Each one qualifies it with its own wait.
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vectors for mem_arbiter.
// Each vector supplies the inputs for one cycle and the outputs expected
// from the state that cycle starts in. Expected outputs pass through a
// queue from the drive point to the sample point on the falling edge.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iREN;
        logic [31:0] iaddr;
        logic        dREN;
        logic        dWEN;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic        rdy;
        logic [31:0] rl;
        logic        eREN;
        logic        eWEN;
        logic [31:0] eAddr;
        logic [31:0] eStore;
        logic        eIw;
        logic        eDw;
    } vec_t;

    typedef struct {
        logic        eREN;
        logic        eWEN;
        logic [31:0] eAddr;
        logic [31:0] eStore;
        logic        eIw;
        logic        eDw;
        logic [31:0] eLoad;
        int          idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   nCmp = 0;
    int   nErr = 0;

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] ds, logic rdy,
                                logic er, logic ew, logic [31:0] ea,
                                logic [31:0] es, logic eiw, logic edw);
        vec_t v;
        v.iREN = ir;
        v.iaddr = ia;
        v.dREN = dr;
        v.dWEN = dw;
        v.daddr = da;
        v.dstore = ds;
        v.rdy = rdy;
        v.rl = $urandom();
        v.eREN = er;
        v.eWEN = ew;
        v.eAddr = ea;
        v.eStore = es;
        v.eIw = eiw;
        v.eDw = edw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector just after the rising edge, then compare on the falling edge.
    task automatic applyVec(input vec_t v, input int idx);
        exp_t e;
        @(posedge CLK);
        #1;
        bus.iREN = v.iREN;
        bus.iaddr = v.iaddr;
        bus.dREN = v.dREN;
        bus.dWEN = v.dWEN;
        bus.daddr = v.daddr;
        bus.dstore = v.dstore;
        bus.ram_ready = v.rdy;
        bus.ramload = v.rl;
        sb.push_back('{v.eREN, v.eWEN, v.eAddr, v.eStore, v.eIw, v.eDw, v.rl, idx});
        @(negedge CLK);
        e = sb.pop_front();
        chk($sformatf("v%0d.ramREN", e.idx), {31'b0, bus.ramREN}, {31'b0, e.eREN});
        chk($sformatf("v%0d.ramWEN", e.idx), {31'b0, bus.ramWEN}, {31'b0, e.eWEN});
        chk($sformatf("v%0d.ramaddr", e.idx), bus.ramaddr, e.eAddr);
        chk($sformatf("v%0d.ramstore", e.idx), bus.ramstore, e.eStore);
        chk($sformatf("v%0d.iwait", e.idx), {31'b0, bus.iwait}, {31'b0, e.eIw});
        chk($sformatf("v%0d.dwait", e.idx), {31'b0, bus.dwait}, {31'b0, e.eDw});
        chk($sformatf("v%0d.iload", e.idx), bus.iload, e.eLoad);
        chk($sformatf("v%0d.dload", e.idx), bus.dload, e.eLoad);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t z;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h44;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b1;
        bus.daddr = 32'h88;
        bus.dstore = 32'h99;
        bus.ram_ready = 1'b1;
        bus.ramload = 32'h0;

        // While reset is held the arbiter shows idle outputs, even across a clock edge.
        #3;
        chk("rst.ramREN", {31'b0, bus.ramREN}, 32'd0);
        chk("rst.ramWEN", {31'b0, bus.ramWEN}, 32'd0);
        chk("rst.ramaddr", bus.ramaddr, 32'd0);
        chk("rst.ramstore", bus.ramstore, 32'd0);
        chk("rst.iwait", {31'b0, bus.iwait}, 32'd1);
        chk("rst.dwait", {31'b0, bus.dwait}, 32'd1);
        @(posedge CLK);
        #1;
        chk("rst.edge.ramREN", {31'b0, bus.ramREN}, 32'd0);
        chk("rst.edge.ramWEN", {31'b0, bus.ramWEN}, 32'd0);
        bus.iREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.ram_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b0;

        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Instruction fetch at 0x40; data returns on the second grant cycle.
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0, 1, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 1, 1, 0, 32'h40, 0, 0, 0));
        tbl[$].rl = 32'hDEADBEEF;
        tbl.push_back(z);
        // Simultaneous requests: the dcache wins first, the icache is served next.
        tbl.push_back(mk(1, 32'h44, 1, 0, 32'h100, 32'hAAAA, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 32'h44, 1, 0, 32'h100, 32'hAAAA, 1, 1, 0, 32'h100, 32'hAAAA, 1, 0));
        tbl.push_back(mk(1, 32'h44, 0, 0, 32'h100, 32'hAAAA, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h44, 0, 0, 32'h100, 32'hAAAA, 1, 1, 0, 32'h44, 0, 0, 0));
        tbl.push_back(z);
        // A write has priority over a simultaneous read; ram_ready in IDLE is ignored.
        tbl.push_back(mk(0, 0, 1, 1, 32'h80, 32'h12345678, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h80, 32'h12345678, 0, 0, 1, 32'h80, 32'h12345678, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h80, 32'h12345678, 1, 0, 1, 32'h80, 32'h12345678, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(z);
        // The dcache withdraws mid-grant: abort to IDLE with no completion.
        tbl.push_back(mk(0, 0, 1, 0, 32'h90, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'h90, 0, 0, 1, 0, 32'h90, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h90, 0, 0, 0, 0, 32'h90, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h90, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(z);
        // Starvation: four dcache completions, then a forced icache grant, then the counter restarts.
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 1, 0, 0, 0, 0, 1, 1));
            tbl.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 1, 1, 0, 32'h300, 0, 1, 0));
        end
        tbl.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 1, 1, 0, 32'h200, 0, 0, 1));
        tbl.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 1, 1, 0, 32'h300, 0, 1, 0));
        tbl.push_back(z);

        for (int i = 0; i < tbl.size(); i++)
            applyVec(tbl[i], i);

        // Saturate the counter, open an icache grant, then reset in the middle of it.
        for (int k = 0; k < 4; k++) begin
            applyVec(mk(1, 32'h60, 1, 0, 32'h70, 0, 1, 0, 0, 0, 0, 1, 1), 100 + 2 * k);
            applyVec(mk(1, 32'h60, 1, 0, 32'h70, 0, 1, 1, 0, 32'h70, 0, 1, 0), 101 + 2 * k);
        end
        applyVec(mk(1, 32'h60, 0, 0, 32'h70, 0, 0, 0, 0, 0, 0, 1, 0), 108);
        applyVec(mk(1, 32'h60, 1, 0, 32'h70, 0, 0, 1, 0, 32'h60, 0, 1, 1), 109);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst.ramREN", {31'b0, bus.ramREN}, 32'd0);
        chk("midrst.ramaddr", bus.ramaddr, 32'd0);
        chk("midrst.iwait", {31'b0, bus.iwait}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        // A cleared counter lets the dcache win at the first edge after release.
        applyVec(mk(1, 32'h60, 1, 0, 32'h70, 0, 1, 1, 0, 32'h70, 0, 1, 0), 110);
        applyVec(z, 111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
